// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// recoded digit flags and the iteration count.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // One radix-4 Booth digit in {-2,-1,0,+1,+2}
    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    // Both operands are widened by two bits, so WIDTH/2 + 1 digit pairs cover them
    function automatic int booth_iters(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth recoder: {b[i+1], b[i], b[i-1]} -> signed digit.
module booth_r4_encoder
    import mult_pkg::*;
(
    input  logic [2:0]   bits,
    output booth_digit_t digit
);

    // 011 -> +2, 100 -> -2; 000 and 111 -> 0; the rest are +/-1
    assign digit.neg  = bits[2];
    assign digit.zero = (bits == 3'b000) || (bits == 3'b111);
    assign digit.two  = (bits == 3'b011) || (bits == 3'b100);

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-4 Booth multiplier: two multiplier bits per cycle through
// one shared adder, with a start/done handshake and runtime signed/unsigned mode.
module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int N  = booth_iters(WIDTH);
    localparam int CW = $clog2(N + 1);
    localparam int EW = WIDTH + 2;
    localparam int AW = WIDTH + 4;

    state_t          state, state_next;
    logic            load, step, finish;
    logic [CW-1:0]   cnt;
    logic [EW-1:0]   a_reg;
    logic [EW-1:0]   mq;
    logic            prev;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   a_wide, mag, addend, sum;
    booth_digit_t    digit;

    booth_r4_encoder u_enc (
        .bits  ({mq[1:0], prev}),
        .digit (digit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A start seen in DONE is accepted exactly as in IDLE, giving gap-free issue
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Two guard bits above the extended multiplicand keep +/-2*A plus the
    // running partial sum from ever overflowing the accumulator
    always_comb begin
        a_wide = {{2{a_reg[EW-1]}}, a_reg};
        mag    = digit.two ? (a_wide << 1) : a_wide;
        addend = digit.zero ? '0 : (digit.neg ? (~mag + AW'(1)) : mag);
        sum    = acc + addend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            a_reg <= '0;
            mq    <= '0;
            prev  <= 1'b0;
            acc   <= '0;
            P     <= '0;
        end else if (load) begin
            a_reg <= signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
            mq    <= signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
            prev  <= 1'b0;
            acc   <= '0;
            cnt   <= CW'(N);
        end else if (step) begin
            acc   <= {{2{sum[AW-1]}}, sum[AW-1:2]};
            mq    <= {sum[1:0], mq[EW-1:2]};
            prev  <= mq[1];
            cnt   <= cnt - CW'(1);
        end else if (finish) begin
            P     <= {acc[WIDTH-3:0], mq};
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed and random checks of seq_booth_multiplier at WIDTH = 32 and WIDTH = 8.
module tb_seq_booth_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0, sm = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic        busy, done;
    logic [63:0] p;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    seq_booth_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .A(a_i), .B(b_i), .busy(busy), .done(done), .P(p)
    );

    seq_booth_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .P(p8)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else   return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        if (s) return $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        else   return {8'b0, a} * {8'b0, b};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Issue one WIDTH=32 operation from the current sample point and follow it to done
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [63:0] res, output int lat, output int bcyc,
                                 output logic overlap);
        start = 1'b1; a_i = a; b_i = b; sm = s;
        @(posedge clk); #1;
        start = 1'b0; a_i = $urandom; b_i = $urandom; sm = ~s;
        lat = 0; bcyc = 0; overlap = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        res = p;
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [15:0] res, output int lat);
        start8 = 1'b1; a8 = a; b8 = b; sm8 = s;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~s;
        lat = 0;
        while (done8 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = p8;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset32: busy=%b done=%b P=%h, required 0 0 0", busy, done, p);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset8: busy=%b done=%b P=%h, required 0 0 0", busy8, done8, p8);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        logic [63:0] res; int lat, bcyc; logic ov;
        // 10 * -5 = -50
        applyStimulus(32'd10, 32'hFFFF_FFFB, 1'b1, res, lat, bcyc, ov);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFCE) begin
            errors++; $display("[TB] FAIL basic_p: got %h, required %h", res, 64'hFFFF_FFFF_FFFF_FFCE);
        end
        checks++;
        if (lat !== 18) begin
            errors++; $display("[TB] FAIL basic_latency: got %0d, required 18", lat);
        end
        // RUN is occupied from the accepting edge through edge k+N: N+1 sampled cycles
        checks++;
        if (bcyc !== 18) begin
            errors++; $display("[TB] FAIL basic_busy_cycles: got %0d, required 18", bcyc);
        end
        checks++;
        if (ov !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_busy_done_overlap: got %b, required 0", ov);
        end
        idle(1);
        checks++;
        if (done !== 1'b0 || p !== 64'hFFFF_FFFF_FFFF_FFCE) begin
            errors++; $display("[TB] FAIL basic_hold: done=%b P=%h, required 0 %h", done, p, 64'hFFFF_FFFF_FFFF_FFCE);
        end
    endtask

    task automatic test_boundary();
        logic [63:0] res; int lat, bcyc; logic ov;
        logic [15:0] r8; int l8;
        logic [31:0] va [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        logic        vs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [63:0] vp [4] = '{64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            idle(1);
            applyStimulus(va[i], vb[i], vs[i], res, lat, bcyc, ov);
            checks++;
            if (res !== vp[i] || lat !== 18) begin
                errors++;
                $display("[TB] FAIL boundary32_%0d: P=%h lat=%0d, required %h lat=18", i, res, lat, vp[i]);
            end
        end
        // WIDTH=8 corners: -128*-128 = 16384, 255*255 = 65025
        idle(1);
        applyStimulus8(8'h80, 8'h80, 1'b1, r8, l8);
        checks++;
        if (r8 !== 16'h4000 || l8 !== 6) begin
            errors++; $display("[TB] FAIL boundary8_minmin: P=%h lat=%0d, required 4000 lat=6", r8, l8);
        end
        idle(1);
        applyStimulus8(8'hFF, 8'hFF, 1'b0, r8, l8);
        checks++;
        if (r8 !== 16'hFE01) begin
            errors++; $display("[TB] FAIL boundary8_maxmax: P=%h, required fe01", r8);
        end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        logic [63:0] seen = '0;
        idle(1);
        start = 1'b1; a_i = 32'd25; b_i = 32'hFFFF_FFF4; sm = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 5) begin start = 1'b1; a_i = 32'd7; b_i = 32'd3; sm = 1'b0; end
            if (c == 6) start = 1'b0;
            if (done === 1'b1) begin dones++; seen = p; end
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("[TB] FAIL ignored_done_count: got %0d, required 1", dones);
        end
        checks++;
        if (seen !== 64'hFFFF_FFFF_FFFF_FED4 || p !== 64'hFFFF_FFFF_FFFF_FED4) begin
            errors++; $display("[TB] FAIL ignored_p: got %h/%h, required %h", seen, p, 64'hFFFF_FFFF_FFFF_FED4);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r1, r2; int l1, l2, b1, b2; logic o1, o2;
        idle(1);
        applyStimulus(32'd3, 32'd4, 1'b1, r1, l1, b1, o1);
        applyStimulus(32'hFFFF_FFF8, 32'd9, 1'b1, r2, l2, b2, o2);
        checks++;
        if (r1 !== 64'd12) begin
            errors++; $display("[TB] FAIL b2b_first: got %h, required %h", r1, 64'd12);
        end
        checks++;
        if (r2 !== 64'hFFFF_FFFF_FFFF_FFB8 || l2 !== 18 || b2 !== 18) begin
            errors++;
            $display("[TB] FAIL b2b_second: P=%h lat=%0d busy=%0d, required %h 18 18", r2, l2, b2, 64'hFFFF_FFFF_FFFF_FFB8);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        idle(1);
        start = 1'b1; a_i = 32'd123; b_i = 32'd456; sm = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(8);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_mid: busy=%b done=%b P=%h, required 0 0 0", busy, done, p);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(20);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_no_resume: busy=%b done=%b P=%h, required 0 0 0", busy, done, p);
        end
    endtask

    task automatic test_random();
        logic [63:0] res, exp32; int lat, bcyc; logic ov;
        logic [15:0] r8, exp8; int l8;
        logic [31:0] a, b; logic s;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            exp32 = ref32(a, b, s);
            applyStimulus(a, b, s, res, lat, bcyc, ov);
            checks++;
            if (res !== exp32) begin
                errors++; $display("[TB] FAIL random32: A=%h B=%h s=%b got %h, required %h", a, b, s, res, exp32);
            end
        end
        idle(1);
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            exp8 = ref8(a[7:0], b[7:0], s);
            applyStimulus8(a[7:0], b[7:0], s, r8, l8);
            checks++;
            if (r8 !== exp8) begin
                errors++; $display("[TB] FAIL random8: A=%h B=%h s=%b got %h, required %h", a[7:0], b[7:0], s, r8, exp8);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
